reverb_st2mm_fifo: RTL and testbench
====================================

# reverb_st2mm_fifo

Parametrised Avalon-ST sink to Avalon-MM slave FIFO that buffers audio samples from the streaming datapath (FIR/reverb outputs) for readout by the Nios II CPU. It generalises the fixed 32x32 stream-to-memory-mapped FIFOs: width and depth are configurable, and it adds a memory-mapped status/control register set, a runtime level-threshold interrupt, a flush command and a saturating counter of samples the source presented while backpressured.

## Interface
- DATA_W, 32: sample width, 1..32; readout is zero-extended to 32 bits.
- ADDR_W, 5: depth = 2^ADDR_W entries, 2..10.
- IRQ_LEVEL, 16: reset value of the threshold register, 0..2^ADDR_W.

Ports:
- wrclock  in  1  sole clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avalonst_sink_data  in  DATA_W  sample.
- avalonst_sink_valid  in  1  sample present.
- avalonst_sink_ready  out  1  FIFO accepts this cycle (ready latency 0).
- avalonmm_slave_address  in  2  register select.
- avalonmm_slave_read  in  1  read strobe.
- avalonmm_slave_write  in  1  write strobe.
- avalonmm_slave_writedata  in  32  write data.
- avalonmm_slave_readdata  out  32  read data, valid in the cycle read is high and waitrequest low.
- avalonmm_slave_waitrequest  out  1  stall.
- irq  out  1  level interrupt.

## Operation
- Register map: 0 = DATA (R, pop); 1 = STATUS (R): [15:0] level, [16] empty, [17] full, [18] irq, [31:24] drop_cnt; 2 = CONTROL (R/W): [0] irq_en (stored), [1] flush (write-1 pulse, reads 0), [2] clr_drop (write-1 pulse, reads 0); 3 = THRESH (R/W): [ADDR_W:0].
- level: ADDR_W+1 bits, 0..DEPTH. empty = (level==0), full = (level==DEPTH). All flags derive from the registered level, never from the current cycle's requests.
- avalonst_sink_ready = reset_n & ~full. A push happens on valid & ready.
- DATA read while not empty: the head entry is driven on readdata combinationally, waitrequest stays low, and the pop commits at the clock edge.
- DATA read while empty: waitrequest is high, readdata = 0, and nothing is popped. The master holds the read and completes in the first cycle empty is low.
- Reads of STATUS/CONTROL/THRESH and all writes never assert waitrequest. A write to DATA or STATUS is ignored.
- Simultaneous push and pop: both occur and level is unchanged. Pop while full frees space from the next cycle only; there is no same-cycle bypass.
- Flush: read/write pointers and level go to 0 at the edge. A push in the same cycle is discarded. drop_cnt is unaffected.
- drop_cnt: 8-bit counter, +1 on each cycle with valid & ~ready, saturating at 255. clr_drop zeroes it, and clear wins over a same-cycle increment.
- irq = irq_en & (level >= THRESH), registered. With THRESH = 0 and irq_en set, irq is permanently high.
- Reset values: pointers, level and drop_cnt = 0; irq_en = 0; THRESH = IRQ_LEVEL; sink_ready = 0 while reset_n is low; waitrequest = 0; readdata = 0; irq = 0. Storage contents are don't-care.
- Reset mid-transfer: all stored samples are lost and an in-progress stalled DATA read is abandoned.

## Timing
- Push to visibility: a sample accepted at edge N is readable, and counted in level, from cycle N+1.
- A pop at edge N updates level/full/ready from cycle N+1.
- irq lags level by one cycle (two cycles after the push edge).
- Throughput: one push and one pop per cycle sustained.
- Pointers wrap modulo 2^ADDR_W.

## Structure
- Package reverb_st2mm_pkg holds the register address constants (ADDR_DATA/STATUS/CONTROL/THRESH), the STATUS/CONTROL bit positions and DROP_W = 8.
- Sub-module reverb_st2mm_fifo_core holds the storage array, read/write pointers, level, empty/full and flush. The top level holds the Avalon decode, the control registers, drop_cnt and irq.

## Test plan
- Default params: push 0x11,0x22,0x33, then read DATA ×3 -> readdata 0x11,0x22,0x33 in order; STATUS[15:0] goes 3 -> 0; empty = 1 at the end.
- Read DATA while empty, then push 0xAB 4 cycles later -> waitrequest high for 5 cycles, then readdata 0xAB with waitrequest low one cycle after the push edge.
- Fill 32 entries with valid held 10 more cycles -> ready low, full = 1, drop_cnt = 10. Hold 300 cycles -> drop_cnt saturates at 255. Write CONTROL = 0x4 -> drop_cnt = 0.
- Simultaneous push/pop at level 5 for 20 cycles -> level stays 5 and the data order is preserved across the pointer wrap.
- THRESH = 4, irq_en = 1, push 4 -> irq rises 2 cycles after the 4th push edge; one pop -> irq falls. Flush -> level 0, and a push in the same cycle is not stored.
- DATA_W = 16, ADDR_W = 2: push 0xFFFF ×4 -> full at 4, readdata = 0x0000FFFF. Assert reset_n low mid-stream -> ready 0, level 0, THRESH back to IRQ_LEVEL.

Source files
------------

// File: rtl/reverb_st2mm_pkg.sv
// Shared constants for the stream-to-memory-mapped sample FIFO: register map,
// STATUS/CONTROL bit positions and the drop counter width.
package reverb_st2mm_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_THRESH  = 2'd3;

    localparam int STAT_LEVEL_LSB = 0;
    localparam int STAT_LEVEL_W   = 16;
    localparam int STAT_EMPTY     = 16;
    localparam int STAT_FULL      = 17;
    localparam int STAT_IRQ       = 18;
    localparam int STAT_DROP_LSB  = 24;

    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_FLUSH    = 1;
    localparam int CTRL_CLR_DROP = 2;

    localparam int DROP_W = 8;

    // Saturating increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/reverb_st2mm_fifo_core.sv
// Sample storage: 2^ADDR_W entry circular buffer with level, empty/full and flush.
// Latency: a push is visible (rd_dat, level) one cycle after its edge; rd_dat is the combinational head.
// Backpressure: push is ignored while full, pop while empty; flush clears and discards a same-cycle push.
module reverb_st2mm_fifo_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH_LVL);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rd_dat  = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    a_level_bound: assert property (@(posedge clock) disable iff (!reset_n) level <= DEPTH_LVL);

endmodule

// File: rtl/reverb_st2mm_fifo.sv
// Avalon-ST sink to Avalon-MM slave sample FIFO with status/control registers, drop counter and level IRQ.
// Latency: pushed sample readable one cycle after its edge; irq follows level by one more cycle.
// Backpressure: sink_ready drops when full; a DATA read on an empty FIFO holds waitrequest until a sample lands.
module reverb_st2mm_fifo
    import reverb_st2mm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int IRQ_LEVEL = 16
) (
    input  logic              wrclock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] avalonst_sink_data,
    input  logic              avalonst_sink_valid,
    output logic              avalonst_sink_ready,
    input  logic [1:0]        avalonmm_slave_address,
    input  logic              avalonmm_slave_read,
    input  logic              avalonmm_slave_write,
    input  logic [31:0]       avalonmm_slave_writedata,
    output logic [31:0]       avalonmm_slave_readdata,
    output logic              avalonmm_slave_waitrequest,
    output logic              irq
);

    localparam logic [ADDR_W:0] THRESH_RST = (ADDR_W + 1)'(IRQ_LEVEL);

    logic [DATA_W-1:0] head_dat;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              rd_data_req;
    logic              wr_ctrl;
    logic              wr_thresh;
    logic              flush;
    logic              clr_drop;
    logic              drop_evt;
    logic              irq_en;
    logic [ADDR_W:0]   thresh;
    logic [DROP_W-1:0] drop_cnt;
    logic              irq_q;
    logic [31:0]       status_word;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign rd_data_req = avalonmm_slave_read & (avalonmm_slave_address == ADDR_DATA);
    assign wr_ctrl     = avalonmm_slave_write & (avalonmm_slave_address == ADDR_CONTROL);
    assign wr_thresh   = avalonmm_slave_write & (avalonmm_slave_address == ADDR_THRESH);
    assign flush       = wr_ctrl & avalonmm_slave_writedata[CTRL_FLUSH];
    assign clr_drop    = wr_ctrl & avalonmm_slave_writedata[CTRL_CLR_DROP];

    assign avalonst_sink_ready = reset_n & ~full;
    assign push                = avalonst_sink_valid & avalonst_sink_ready;
    assign drop_evt            = avalonst_sink_valid & ~avalonst_sink_ready;
    assign pop                 = rd_data_req & ~empty;

    // Stall is driven from the registered level only, so a same-cycle push never short-circuits it.
    assign avalonmm_slave_waitrequest = reset_n & rd_data_req & empty;

    assign irq          = irq_q;
    assign unused_wdata = ^avalonmm_slave_writedata[31:ADDR_W+1];

    reverb_st2mm_fifo_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clock   (wrclock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_dat  (avalonst_sink_data),
        .rd_dat  (head_dat),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(level);
        status_word[STAT_EMPTY]                     = empty;
        status_word[STAT_FULL]                      = full;
        status_word[STAT_IRQ]                       = irq_q;
        status_word[STAT_DROP_LSB +: DROP_W]        = drop_cnt;

        rd_mux = '0;
        case (avalonmm_slave_address)
            ADDR_DATA:    rd_mux = empty ? 32'h0 : 32'(head_dat);
            ADDR_STATUS:  rd_mux = status_word;
            ADDR_CONTROL: rd_mux[CTRL_IRQ_EN] = irq_en;
            default:      rd_mux = 32'(thresh);
        endcase
    end

    assign avalonmm_slave_readdata = (reset_n & avalonmm_slave_read) ? rd_mux : 32'h0;

    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= 1'b0;
            thresh   <= THRESH_RST;
            drop_cnt <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= avalonmm_slave_writedata[CTRL_IRQ_EN];
            end
            if (wr_thresh) begin
                thresh <= avalonmm_slave_writedata[ADDR_W:0];
            end
            // Clear takes priority over a drop seen in the same cycle.
            if (clr_drop) begin
                drop_cnt <= '0;
            end else if (drop_evt) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            irq_q <= irq_en & (level >= thresh);
        end
    end

endmodule

// File: tb/tb_reverb_st2mm_fifo.sv
// Randomised and directed checks of reverb_st2mm_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_reverb_st2mm_fifo;

    localparam int DEPTH = 32;

    logic        wrclock = 1'b0;
    logic        reset_n;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  mm_addr;
    logic        mm_read;
    logic        mm_write;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;
    logic        mm_wait;
    logic        irq;

    logic        rst2_n;
    logic [15:0] s2_data;
    logic        s2_valid;
    logic        s2_ready;
    logic [1:0]  a2_addr;
    logic        a2_read;
    logic        a2_write;
    logic [31:0] a2_wdata;
    logic [31:0] a2_rdata;
    logic        a2_wait;
    logic        irq2;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mq[$];
    int          m_drop = 0;

    always #5 wrclock = ~wrclock;

    reverb_st2mm_fifo #(.DATA_W(32), .ADDR_W(5), .IRQ_LEVEL(16)) dut (
        .wrclock                    (wrclock),
        .reset_n                    (reset_n),
        .avalonst_sink_data         (st_data),
        .avalonst_sink_valid        (st_valid),
        .avalonst_sink_ready        (st_ready),
        .avalonmm_slave_address     (mm_addr),
        .avalonmm_slave_read        (mm_read),
        .avalonmm_slave_write       (mm_write),
        .avalonmm_slave_writedata   (mm_wdata),
        .avalonmm_slave_readdata    (mm_rdata),
        .avalonmm_slave_waitrequest (mm_wait),
        .irq                        (irq)
    );

    reverb_st2mm_fifo #(.DATA_W(16), .ADDR_W(2), .IRQ_LEVEL(3)) dut2 (
        .wrclock                    (wrclock),
        .reset_n                    (rst2_n),
        .avalonst_sink_data         (s2_data),
        .avalonst_sink_valid        (s2_valid),
        .avalonst_sink_ready        (s2_ready),
        .avalonmm_slave_address     (a2_addr),
        .avalonmm_slave_read        (a2_read),
        .avalonmm_slave_write       (a2_write),
        .avalonmm_slave_writedata   (a2_wdata),
        .avalonmm_slave_readdata    (a2_rdata),
        .avalonmm_slave_waitrequest (a2_wait),
        .irq                        (irq2)
    );

    function automatic logic [31:0] exp_status(int lvl, int depth, logic ir, int drop);
        logic [31:0] s;
        s = 32'(lvl);
        if (lvl == 0)     s = s | 32'h0001_0000;
        if (lvl == depth) s = s | 32'h0002_0000;
        if (ir)           s = s | 32'h0004_0000;
        s = s | (32'(drop) << 24);
        return s;
    endfunction

    task automatic tick();
        @(posedge wrclock);
        #1;
    endtask

    task automatic mm_rd(input logic [1:0] addr, output logic [31:0] data);
        mm_addr = addr;
        mm_read = 1'b1;
        @(negedge wrclock);
        data = mm_rdata;
        tick();
        mm_read = 1'b0;
    endtask

    task automatic mm_wr(input logic [1:0] addr, input logic [31:0] data);
        mm_addr  = addr;
        mm_wdata = data;
        mm_write = 1'b1;
        tick();
        mm_write = 1'b0;
    endtask

    task automatic a2_rd(input logic [1:0] addr, output logic [31:0] data);
        a2_addr = addr;
        a2_read = 1'b1;
        @(negedge wrclock);
        data = a2_rdata;
        tick();
        a2_read = 1'b0;
    endtask

    task automatic push_n(input int n);
        st_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            st_data = $urandom;
            mq.push_back(st_data);
            tick();
        end
        st_valid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        int n;
        logic [31:0] e;
        n = mq.size();
        mm_addr = 2'd0;
        mm_read = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge wrclock);
            e = mq.pop_front();
            tests++;
            if (mm_rdata !== e || mm_wait !== 1'b0) begin
                fails++;
                $display("FAIL %s[%0d]: readdata=%h wait=%b, expected %h wait=0", name, i, mm_rdata, mm_wait, e);
            end
            tick();
        end
        mm_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset_n = 1'b0; rst2_n = 1'b0;
        st_valid = 1'b0; st_data = 32'h0;
        mm_addr = 2'd0; mm_read = 1'b1; mm_write = 1'b0; mm_wdata = 32'h0;
        s2_valid = 1'b0; s2_data = 16'h0;
        a2_addr = 2'd0; a2_read = 1'b0; a2_write = 1'b0; a2_wdata = 32'h0;
        repeat (3) @(posedge wrclock);
        #1;
        @(negedge wrclock);
        tests++;
        if (st_ready !== 1'b0 || mm_wait !== 1'b0 || mm_rdata !== 32'h0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b wait=%b rdata=%h irq=%b, expected 0 0 0 0", st_ready, mm_wait, mm_rdata, irq);
        end
        tick();
        mm_read = 1'b0;
        reset_n = 1'b1; rst2_n = 1'b1;
        tick();
        mm_rd(2'd1, r);
        tests++;
        if (r !== 32'h0001_0000) begin
            fails++; $display("FAIL reset_status: got %h expected 00010000", r);
        end
        mm_rd(2'd3, r);
        tests++;
        if (r !== 32'd16) begin
            fails++; $display("FAIL reset_thresh: got %h expected 00000010", r);
        end
        mm_rd(2'd2, r);
        tests++;
        if (r !== 32'h0) begin
            fails++; $display("FAIL reset_control: got %h expected 00000000", r);
        end
        @(negedge wrclock);
        tests++;
        if (st_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_reset: got %b expected 1", st_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] r;
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        st_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_data = vals[i];
            mq.push_back(vals[i]);
            tick();
        end
        st_valid = 1'b0;
        mm_rd(2'd1, r);
        tests++;
        if (r !== 32'h0000_0003) begin
            fails++; $display("FAIL basic_level3: got %h expected 00000003", r);
        end
        drain_check("basic_data");
        mm_rd(2'd1, r);
        tests++;
        if (r !== 32'h0001_0000) begin
            fails++; $display("FAIL basic_empty: got %h expected 00010000", r);
        end
    endtask

    task automatic test_stall();
        mm_addr = 2'd0;
        mm_read = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                st_valid = 1'b1;
                st_data  = 32'hAB;
            end
            @(negedge wrclock);
            tests++;
            if (mm_wait !== 1'b1 || mm_rdata !== 32'h0) begin
                fails++; $display("FAIL stall_cycle%0d: wait=%b rdata=%h expected wait=1 rdata=0", c, mm_wait, mm_rdata);
            end
            tick();
            st_valid = 1'b0;
        end
        @(negedge wrclock);
        tests++;
        if (mm_wait !== 1'b0 || mm_rdata !== 32'hAB) begin
            fails++; $display("FAIL stall_complete: wait=%b rdata=%h expected wait=0 rdata=000000ab", mm_wait, mm_rdata);
        end
        tick();
        mm_read = 1'b0;
    endtask

    task automatic test_drop();
        logic [31:0] r;
        logic        er;
        st_valid = 1'b1;
        for (int i = 0; i < 42; i++) begin
            st_data = $urandom;
            @(negedge wrclock);
            er = (mq.size() != DEPTH);
            tests++;
            if (st_ready !== er) begin
                fails++; $display("FAIL drop_ready[%0d]: got %b expected %b", i, st_ready, er);
            end
            if (er) mq.push_back(st_data);
            else if (m_drop < 255) m_drop++;
            tick();
        end
        st_valid = 1'b0;
        mm_rd(2'd1, r);
        tests++;
        if (r !== exp_status(mq.size(), DEPTH, 1'b0, m_drop) || r[31:24] !== 8'd10 || r[17] !== 1'b1) begin
            fails++; $display("FAIL drop_10: got %h expected %h", r, exp_status(mq.size(), DEPTH, 1'b0, m_drop));
        end
        st_valid = 1'b1;
        repeat (300) begin
            st_data = $urandom;
            if (m_drop < 255) m_drop++;
            tick();
        end
        st_valid = 1'b0;
        mm_rd(2'd1, r);
        tests++;
        if (r[31:24] !== 8'd255 || r !== exp_status(mq.size(), DEPTH, 1'b0, m_drop)) begin
            fails++; $display("FAIL drop_saturate: got %h expected %h", r, exp_status(mq.size(), DEPTH, 1'b0, m_drop));
        end
        mm_wr(2'd2, 32'h4);
        m_drop = 0;
        mm_rd(2'd1, r);
        tests++;
        if (r !== exp_status(mq.size(), DEPTH, 1'b0, 0)) begin
            fails++; $display("FAIL drop_clear: got %h expected %h", r, exp_status(mq.size(), DEPTH, 1'b0, 0));
        end
        drain_check("full_drain");
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [31:0] e;
        push_n(20);
        drain_check("wrap_pre");
        push_n(5);
        st_valid = 1'b1;
        mm_addr  = 2'd0;
        mm_read  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            st_data = $urandom;
            @(negedge wrclock);
            e = mq[0];
            tests++;
            if (mm_rdata !== e || mm_wait !== 1'b0 || st_ready !== 1'b1) begin
                fails++; $display("FAIL b2b[%0d]: rdata=%h wait=%b ready=%b expected %h 0 1", i, mm_rdata, mm_wait, st_ready, e);
            end
            void'(mq.pop_front());
            mq.push_back(st_data);
            tick();
        end
        st_valid = 1'b0;
        mm_read  = 1'b0;
        mm_rd(2'd1, r);
        tests++;
        if (r !== 32'h0000_0005) begin
            fails++; $display("FAIL b2b_level: got %h expected 00000005", r);
        end
        drain_check("b2b_drain");
    endtask

    task automatic test_irq_flush();
        logic [31:0] r;
        mm_wr(2'd3, 32'd4);
        mm_wr(2'd2, 32'h1);
        push_n(4);
        @(negedge wrclock);
        tests++;
        if (irq !== 1'b0) begin
            fails++; $display("FAIL irq_lag1: got %b expected 0", irq);
        end
        tick();
        @(negedge wrclock);
        tests++;
        if (irq !== 1'b1) begin
            fails++; $display("FAIL irq_rise: got %b expected 1", irq);
        end
        tick();
        mm_addr = 2'd0;
        mm_read = 1'b1;
        @(negedge wrclock);
        tests++;
        if (mm_rdata !== mq[0]) begin
            fails++; $display("FAIL irq_pop_data: got %h expected %h", mm_rdata, mq[0]);
        end
        tick();
        mm_read = 1'b0;
        void'(mq.pop_front());
        @(negedge wrclock);
        tests++;
        if (irq !== 1'b1) begin
            fails++; $display("FAIL irq_hold: got %b expected 1", irq);
        end
        tick();
        @(negedge wrclock);
        tests++;
        if (irq !== 1'b0) begin
            fails++; $display("FAIL irq_fall: got %b expected 0", irq);
        end
        tick();
        st_valid = 1'b1;
        st_data  = 32'h5A;
        mm_wr(2'd2, 32'h3);
        st_valid = 1'b0;
        mq.delete();
        mm_rd(2'd1, r);
        tests++;
        if (r !== 32'h0001_0000) begin
            fails++; $display("FAIL flush_status: got %h expected 00010000", r);
        end
        mm_addr = 2'd0;
        mm_read = 1'b1;
        @(negedge wrclock);
        tests++;
        if (mm_wait !== 1'b1 || mm_rdata !== 32'h0) begin
            fails++; $display("FAIL flush_push_dropped: wait=%b rdata=%h expected 1 0", mm_wait, mm_rdata);
        end
        tick();
        mm_read = 1'b0;
        mm_wr(2'd3, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge wrclock);
            tests++;
            if (irq !== 1'b1) begin
                fails++; $display("FAIL irq_thresh0[%0d]: got %b expected 1", i, irq);
            end
            tick();
        end
        mm_wr(2'd2, 32'h0);
        mm_wr(2'd3, 32'd4);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        v;
        logic        rd;
        logic        fl;
        logic        exp_irq;
        int          thr;
        int          n;
        thr = $urandom_range(1, 31);
        mm_wr(2'd3, 32'(thr));
        mm_wr(2'd2, 32'h1);
        exp_irq = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            v  = (cyc < 300) ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 35);
            rd = (cyc < 300) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 70);
            fl = ($urandom_range(0, 99) < 2);
            if (fl) rd = 1'b0;
            st_valid = v;
            st_data  = $urandom;
            mm_addr  = fl ? 2'd2 : 2'd0;
            mm_read  = rd;
            mm_write = fl;
            mm_wdata = 32'h3;
            @(negedge wrclock);
            n = mq.size();
            tests++;
            if (st_ready !== (n != DEPTH) || irq !== exp_irq) begin
                fails++; $display("FAIL rand_flags[%0d]: ready=%b irq=%b level=%0d expected irq=%b", cyc, st_ready, irq, n, exp_irq);
            end
            if (rd) begin
                tests++;
                if (mm_wait !== (n == 0) || mm_rdata !== ((n != 0) ? mq[0] : 32'h0)) begin
                    fails++; $display("FAIL rand_read[%0d]: wait=%b rdata=%h level=%0d", cyc, mm_wait, mm_rdata, n);
                end
            end
            exp_irq = (n >= thr);
            if (v && n == DEPTH && m_drop < 255) m_drop++;
            if (fl) begin
                mq.delete();
            end else begin
                if (rd && n != 0) void'(mq.pop_front());
                if (v && n != DEPTH) mq.push_back(st_data);
            end
            tick();
        end
        st_valid = 1'b0; mm_read = 1'b0; mm_write = 1'b0;
        mm_rd(2'd1, r);
        tests++;
        if (r !== exp_status(mq.size(), DEPTH, exp_irq, m_drop)) begin
            fails++; $display("FAIL rand_status: got %h expected %h", r, exp_status(mq.size(), DEPTH, exp_irq, m_drop));
        end
        mm_wr(2'd2, 32'h4);
        m_drop = 0;
    endtask

    task automatic test_small_cfg();
        logic [31:0] r;
        s2_valid = 1'b1;
        s2_data  = 16'hFFFF;
        repeat (4) tick();
        @(negedge wrclock);
        tests++;
        if (s2_ready !== 1'b0) begin
            fails++; $display("FAIL small_ready_full: got %b expected 0", s2_ready);
        end
        tick();
        s2_valid = 1'b0;
        a2_rd(2'd1, r);
        tests++;
        if (r !== 32'h0002_0004 + (32'd1 << 24)) begin
            fails++; $display("FAIL small_status_full: got %h expected 01020004", r);
        end
        a2_addr = 2'd0;
        a2_read = 1'b1;
        @(negedge wrclock);
        tests++;
        if (a2_rdata !== 32'h0000_FFFF || a2_wait !== 1'b0 || irq2 !== 1'b0) begin
            fails++; $display("FAIL small_readdata: rdata=%h wait=%b irq=%b expected 0000ffff 0 0", a2_rdata, a2_wait, irq2);
        end
        tick();
        a2_read  = 1'b0;
        a2_addr  = 2'd3;
        a2_wdata = 32'd1;
        a2_write = 1'b1;
        tick();
        a2_write = 1'b0;
        s2_valid = 1'b1;
        rst2_n   = 1'b0;
        @(negedge wrclock);
        tests++;
        if (s2_ready !== 1'b0) begin
            fails++; $display("FAIL small_reset_ready: got %b expected 0", s2_ready);
        end
        tick();
        s2_valid = 1'b0;
        rst2_n   = 1'b1;
        tick();
        a2_rd(2'd1, r);
        tests++;
        if (r !== 32'h0001_0000) begin
            fails++; $display("FAIL small_reset_status: got %h expected 00010000", r);
        end
        a2_rd(2'd3, r);
        tests++;
        if (r !== 32'd3) begin
            fails++; $display("FAIL small_reset_thresh: got %h expected 00000003", r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_back_to_back();
        test_irq_flush();
        test_random();
        test_small_cfg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
